ring_capture_of_verifla: RTL and testbench

RING_CAPTURE_OF_VERIFLA -- requirements
Module: ring_capture_of_verifla

---
 rtl/ring_capture_of_verifla.sv | 229 ++++++++++++++++++++++
 tb/tb_ring_capture_of_verifla.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_capture_of_verifla.sv
// Trigger-centred ring capture buffer: clears, records samples around a trigger,
// then replays the stored window oldest-first over a valid/ready stream.
module ring_capture_of_verifla #(
  parameter int                   DATA_BITS  = 16,
  parameter int                   ADDR_BITS  = 8,
  parameter logic [DATA_BITS-1:0] EMPTY_SLOT = {DATA_BITS{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 trig,
  input  logic [ADDR_BITS-1:0] post_len,
  input  logic                 rd_start,
  input  logic                 rd_ready,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 rd_last,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] trig_addr,
  output logic [ADDR_BITS:0]   fill_count
);

  localparam int                   DEPTH     = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ZERO_A    = {ADDR_BITS{1'b0}};
  localparam logic [ADDR_BITS-1:0] ONE_A     = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};
  localparam logic [ADDR_BITS:0]   ZERO_F    = {(ADDR_BITS+1){1'b0}};
  localparam logic [ADDR_BITS:0]   ONE_F     = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   FULL_F    = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_CAPTURE = 3'd1,
    S_POST    = 3'd2,
    S_DONE    = 3'd3,
    S_READ    = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [ADDR_BITS-1:0] clr_addr_r;
  logic [ADDR_BITS-1:0] wr_ptr_r;
  logic [ADDR_BITS-1:0] post_cnt_r;
  logic [ADDR_BITS-1:0] rd_addr_r;
  logic [ADDR_BITS:0]   rd_left_r;
  logic [ADDR_BITS:0]   fill_r;
  logic [ADDR_BITS-1:0] trig_addr_r;
  logic [DATA_BITS-1:0] ram_q_r;
  logic                 rd_valid_r;
  logic                 rd_last_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 cap_s;
  logic                 fetch_s;
  logic                 xfer_s;
  logic                 mem_we_s;
  logic [ADDR_BITS-1:0] mem_waddr_s;
  logic [DATA_BITS-1:0] mem_wdata_s;

  logic [DATA_BITS-1:0] mem [DEPTH];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_CLEAR;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and per-cycle strobes.
  always_comb begin
    state_s = state_r;
    cap_s   = 1'b0;
    fetch_s = 1'b0;
    xfer_s  = rd_valid_r & rd_ready;
    case (state_r)
      S_CLEAR: begin
        if (clr_addr_r == LAST_ADDR) begin
          state_s = S_CAPTURE;
        end else begin
          state_s = S_CLEAR;
        end
      end
      S_CAPTURE: begin
        cap_s = wr_en;
        if (wr_en && trig) begin
          if (post_len == ZERO_A) begin
            state_s = S_DONE;
          end else begin
            state_s = S_POST;
          end
        end else begin
          state_s = S_CAPTURE;
        end
      end
      S_POST: begin
        cap_s = wr_en;
        if (wr_en && (post_cnt_r == ONE_A)) begin
          state_s = S_DONE;
        end else begin
          state_s = S_POST;
        end
      end
      S_DONE: begin
        if (rd_start) begin
          state_s = S_READ;
        end else begin
          state_s = S_DONE;
        end
      end
      S_READ: begin
        // Refill the output register whenever it is empty or being consumed.
        fetch_s = (rd_left_r != ZERO_F) && (!rd_valid_r || rd_ready);
        if (xfer_s && rd_last_r) begin
          state_s = S_CLEAR;
        end else begin
          state_s = S_READ;
        end
      end
      default: begin
        state_s = S_CLEAR;
      end
    endcase
  end

  // Write-port steering: clear sweep or live samples.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = wr_ptr_r;
    mem_wdata_s = wr_data;
    if (rst) begin
      mem_we_s = 1'b0;
    end else if (state_r == S_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_addr_r;
      mem_wdata_s = EMPTY_SLOT;
    end else begin
      mem_we_s = cap_s;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Registered read port; it doubles as the rd_data holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_q_r <= EMPTY_SLOT;
    end else if (fetch_s) begin
      ram_q_r <= mem[rd_addr_r];
    end
  end

  // Pointers, counters and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr_r  <= ZERO_A;
      wr_ptr_r    <= ZERO_A;
      post_cnt_r  <= ZERO_A;
      rd_addr_r   <= ZERO_A;
      rd_left_r   <= ZERO_F;
      fill_r      <= ZERO_F;
      trig_addr_r <= ZERO_A;
      rd_valid_r  <= 1'b0;
      rd_last_r   <= 1'b0;
      busy_r      <= 1'b1;
      done_r      <= 1'b0;
    end else begin
      if (state_r == S_CLEAR) begin
        clr_addr_r <= clr_addr_r + ONE_A;
      end else begin
        clr_addr_r <= ZERO_A;
      end

      if ((state_r == S_READ) && (state_s == S_CLEAR)) begin
        wr_ptr_r <= ZERO_A;
        fill_r   <= ZERO_F;
      end else if (cap_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_A;
        if (fill_r != FULL_F) begin
          fill_r <= fill_r + ONE_F;
        end
      end

      if ((state_r == S_CAPTURE) && cap_s && trig) begin
        trig_addr_r <= wr_ptr_r;
        post_cnt_r  <= post_len;
      end else if ((state_r == S_POST) && cap_s) begin
        post_cnt_r <= post_cnt_r - ONE_A;
      end

      // Oldest word sits at wr_ptr once the ring has wrapped, else at 0.
      if ((state_r == S_DONE) && rd_start) begin
        rd_addr_r <= (fill_r == FULL_F) ? wr_ptr_r : ZERO_A;
        rd_left_r <= fill_r;
      end else if (fetch_s) begin
        rd_addr_r <= rd_addr_r + ONE_A;
        rd_left_r <= rd_left_r - ONE_F;
      end

      if (fetch_s) begin
        rd_valid_r <= 1'b1;
        rd_last_r  <= (rd_left_r == ONE_F);
      end else if (xfer_s) begin
        rd_valid_r <= 1'b0;
        rd_last_r  <= 1'b0;
      end

      busy_r <= (state_s == S_CLEAR);
      done_r <= (state_s == S_DONE);
    end
  end

  assign rd_data    = ram_q_r;
  assign rd_valid   = rd_valid_r;
  assign rd_last    = rd_last_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign trig_addr  = trig_addr_r;
  assign fill_count = fill_r;

endmodule

// File: tb/tb_ring_capture_of_verifla.sv
// Scoreboard bench for ring_capture_of_verifla (8-bit data, 16-word ring).
module tb_ring_capture_of_verifla;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       trig;
  logic [3:0] post_len;
  logic       rd_start;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_last;
  logic       busy;
  logic       done;
  logic [3:0] trig_addr;
  logic [4:0] fill_count;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;

  ring_capture_of_verifla #(
    .DATA_BITS (8),
    .ADDR_BITS (4),
    .EMPTY_SLOT(8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .trig      (trig),
    .post_len  (post_len),
    .rd_start  (rd_start),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .busy      (busy),
    .done      (done),
    .trig_addr (trig_addr),
    .fill_count(fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [7:0] d, input logic t);
    wr_en   = 1'b1;
    wr_data = d;
    trig    = t;
    tick();
    wr_en = 1'b0;
    trig  = 1'b0;
  endtask

  // Sweep must last 16 cycles, stay quiet, and ignore wr_en.
  task automatic wait_clear(input string tag);
    int n;
    bit bad;
    n   = 0;
    bad = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    while (busy && n < 40) begin
      if (done || rd_valid || fill_count != 5'd0) bad = 1'b1;
      tick();
      n++;
    end
    wr_en = 1'b0;
    chk({tag, "_clear_cycles"}, n, 32'd16);
    chk({tag, "_clear_quiet"}, bad, 32'd0);
    chk({tag, "_fill_after_clear"}, fill_count, 32'd0);
    chk({tag, "_done_after_clear"}, done, 32'd0);
  endtask

  task automatic load_a();
    post_len = 4'd2;
    for (int d = 1; d <= 4; d++) wr(d[7:0], 1'b0);
    wr(8'h05, 1'b1);
    wr(8'h06, 1'b0);
    wr(8'h07, 1'b0);
  endtask

  task automatic push_a();
    for (int d = 1; d <= 7; d++) push(d[7:0], d == 7);
  endtask

  task automatic readout(input string tag, input int limit, input bit toggle);
    int n;
    rd_ready = 1'b1;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    n = 1;
    while (exp_q.size() != 0 && n < 200) begin
      if (toggle) rd_ready = ~rd_ready;
      tick();
      n++;
    end
    rd_ready = 1'b1;
    chk({tag, "_drained"}, exp_q.size(), 32'd0);
    chk({tag, "_drain_cycles_ok"}, n <= limit, 32'd1);
    chk({tag, "_busy_after_read"}, busy, 32'd1);
    chk({tag, "_done_after_read"}, done, 32'd0);
    chk({tag, "_fill_after_read"}, fill_count, 32'd0);
    chk({tag, "_valid_after_read"}, rd_valid, 32'd0);
  endtask

  // Monitor: compare every presented word against the queue head; pop on transfer.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got word %0h, expected no word", rd_data);
      end else begin
        chk("rd_data", rd_data, exp_q[0].data);
        chk("rd_last", rd_last, exp_q[0].last);
        if (rd_ready) begin
          void'(exp_q.pop_front());
          xfers++;
        end
      end
    end
  end

  initial begin
    int n;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    trig     = 1'b0;
    post_len = 4'd0;
    rd_start = 1'b0;
    rd_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 32'd1);
    chk("rst_done", done, 32'd0);
    chk("rst_rd_valid", rd_valid, 32'd0);
    chk("rst_rd_last", rd_last, 32'd0);
    chk("rst_rd_data", rd_data, 32'hA5);
    chk("rst_fill", fill_count, 32'd0);
    chk("rst_trig_addr", trig_addr, 32'd0);
    rst = 1'b0;
    wait_clear("init");

    // No-wrap capture with ignored events sprinkled in.
    post_len = 4'd2;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("a_idle_fill", fill_count, 32'd0);
    chk("a_idle_done", done, 32'd0);
    for (int d = 1; d <= 4; d++) wr(d[7:0], 1'b0);
    wr(8'h05, 1'b1);
    chk("a_post_fill", fill_count, 32'd5);
    chk("a_post_done", done, 32'd0);
    wr(8'h06, 1'b1);
    chk("a_trig_in_post", trig_addr, 32'd4);
    wr(8'h07, 1'b0);
    chk("a_done", done, 32'd1);
    chk("a_trig_addr", trig_addr, 32'd4);
    chk("a_fill", fill_count, 32'd7);
    wr(8'h99, 1'b1);
    chk("a_wr_in_done_fill", fill_count, 32'd7);
    chk("a_wr_in_done_trig", trig_addr, 32'd4);
    chk("a_wr_in_done_state", done, 32'd1);
    push_a();
    readout("a", 9, 1'b0);
    chk("a_trig_addr_kept", trig_addr, 32'd4);
    wait_clear("a");

    // Wrapped capture: 20 samples into a 16-word ring.
    post_len = 4'd0;
    for (int d = 0; d < 20; d++) wr(d[7:0], d == 19);
    chk("b_done", done, 32'd1);
    chk("b_fill", fill_count, 32'd16);
    chk("b_trig_addr", trig_addr, 32'd3);
    for (int d = 4; d < 20; d++) push(d[7:0], d == 19);
    readout("b", 18, 1'b0);
    wait_clear("b");

    // Backpressure: rd_ready toggles every cycle.
    load_a();
    chk("c_done", done, 32'd1);
    push_a();
    readout("c", 40, 1'b1);
    wait_clear("c");

    // Reset while the third word is on the output.
    load_a();
    chk("d_done", done, 32'd1);
    push_a();
    n = xfers;
    rd_ready = 1'b1;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 20 && xfers < n + 2; i++) tick();
    chk("d_two_words_out", xfers - n, 32'd2);
    chk("d_third_valid", rd_valid, 32'd1);
    rst = 1'b1;
    rd_ready = 1'b0;
    tick();
    exp_q.delete();
    chk("d_rst_rd_valid", rd_valid, 32'd0);
    chk("d_rst_done", done, 32'd0);
    chk("d_rst_busy", busy, 32'd1);
    chk("d_rst_fill", fill_count, 32'd0);
    chk("d_rst_rd_data", rd_data, 32'hA5);
    chk("d_rst_trig_addr", trig_addr, 32'd0);
    rst = 1'b0;
    wait_clear("d");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
